// File: rtl/usb_pkg.sv
// Shared types and constants for the USB serial transmit scheduler.
package usb_pkg;

    localparam logic [7:0]  SYNC_BYTE          = 8'h80;
    localparam int unsigned EOP_CYCLES_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        EOP
    } tx_state_t;

endpackage

// File: rtl/usb_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic [PTR_W-1:0]   next_ptr
);

    logic [PTR_W-1:0] idx;

    // Scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        next_ptr  = ptr;
        idx       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % int'(NUM_REQ));
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                next_ptr   = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Serial transmit sequencer: arbitrates packet sources, sends SYNC + bytes LSB-first, then EOP.
module usb_tx_scheduler
    import usb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 2,
    parameter  int unsigned EOP_CYCLES = usb_pkg::EOP_CYCLES_DEFAULT,
    localparam int unsigned PTR_W      = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 stuff_stall,
    output logic                 out_bit,
    output logic                 bs_sending,
    output logic                 eop,
    output logic                 busy,
    output logic [PTR_W-1:0]     grant_id,
    output logic                 underrun
);

    localparam int unsigned EOP_W = $clog2(EOP_CYCLES + 1);

    tx_state_t          state;
    logic [7:0]         shift;
    logic [2:0]         bit_cnt;
    logic               last_flag;
    logic [EOP_W-1:0]   eop_cnt;
    logic [PTR_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   arb_next;

    logic               gnt_valid;
    logic               gnt_last;
    logic [7:0]         gnt_data;
    logic               advance;
    logic               boundary;
    logic               load;
    logic               take;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .next_ptr  (arb_next)
    );

    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == PTR_W'(i)) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = req_data[i*8 +: 8];
            end
        end
    end

    // A byte boundary is the unstalled final bit of SYNC or of a data byte.
    always_comb begin
        advance  = (state == SYNC || state == DATA) && !stuff_stall;
        boundary = advance && (bit_cnt == 3'd7);
        load     = boundary && (state == SYNC || !last_flag);
        take     = load && gnt_valid;
        underrun = load && !gnt_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = take && (grant_id == PTR_W'(i));
        end
    end

    assign out_bit = shift[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            last_flag  <= 1'b0;
            eop_cnt    <= '0;
            rr_ptr     <= '0;
            grant_id   <= '0;
            bs_sending <= 1'b0;
            eop        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|arb_grant) begin
                        grant_id   <= arb_idx;
                        rr_ptr     <= arb_next;
                        shift      <= SYNC_BYTE;
                        bit_cnt    <= '0;
                        last_flag  <= 1'b0;
                        state      <= SYNC;
                        bs_sending <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SYNC, DATA: begin
                    if (advance) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (take) begin
                            shift     <= gnt_data;
                            last_flag <= gnt_last;
                            state     <= DATA;
                        end else if (boundary) begin
                            state      <= EOP;
                            bs_sending <= 1'b0;
                            eop        <= 1'b1;
                            eop_cnt    <= '0;
                        end
                    end
                end
                EOP: begin
                    if (eop_cnt == EOP_W'(EOP_CYCLES - 1)) begin
                        state <= IDLE;
                        eop   <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        eop_cnt <= eop_cnt + EOP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Self-checking bench for usb_tx_scheduler against a bit-list wire model.
module tb_usb_tx_scheduler;

    localparam int NR   = 2;
    localparam int EOPC = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            stuff_stall;
    logic            out_bit;
    logic            bs_sending;
    logic            eop;
    logic            busy;
    logic [0:0]      grant_id;
    logic            underrun;

    usb_tx_scheduler #(
        .NUM_REQ    (NR),
        .EOP_CYCLES (EOPC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .stuff_stall (stuff_stall),
        .out_bit     (out_bit),
        .bs_sending  (bs_sending),
        .eop         (eop),
        .busy        (busy),
        .grant_id    (grant_id),
        .underrun    (underrun)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] qd [NR][$];
    logic       ql [NR][$];
    bit         drop_valid [NR];
    int         stall_plan [$];
    bit         rand_stall_idle;
    int         bs_seen;

    bit lg_bs[$], lg_bit[$], lg_stall[$], lg_eop[$], lg_busy[$], lg_und[$];
    int lg_rdy[$], lg_gid[$];

    typedef struct {
        int bs_cnt; int last_bs; int eop_cnt; int first_eop; int last_eop;
        int rdy_cnt; int rdy_bs; int rdy_err; int bit_err; int und_cnt; int und_idx;
        int gid; bit busy_end;
    } stats_t;

    function automatic bit planned(input int k);
        foreach (stall_plan[j]) if (stall_plan[j] == k) return 1'b1;
        return 1'b0;
    endfunction

    // Expected wire content: SYNC byte then each data byte, all LSB first.
    function automatic void exp_wire(input logic [7:0] by[$], output bit eb[$]);
        logic [7:0] w;
        eb = {};
        w = 8'h80;
        for (int b = 0; b < 8; b++) eb.push_back(w[b]);
        foreach (by[k]) begin
            w = by[k];
            for (int b = 0; b < 8; b++) eb.push_back(w[b]);
        end
    endfunction

    // Walks the log against the wire model: stalled cycles repeat the current bit, and a
    // requester byte is consumed on the unstalled last bit of every byte that has a successor.
    function automatic stats_t analyse(input bit eb[$], input int req);
        stats_t s;
        int pos, nbs, wantv;
        s = '{default: 0};
        s.last_bs = -1; s.first_eop = -1; s.rdy_bs = -1; s.und_idx = -1; s.gid = -1;
        pos = 0; nbs = 0;
        for (int i = 0; i < lg_bs.size(); i++) begin
            if (lg_eop[i]) begin
                if (s.first_eop < 0) s.first_eop = i;
                s.last_eop = i;
                s.eop_cnt++;
            end
            if (lg_und[i]) begin s.und_cnt++; s.und_idx = i; end
            if (lg_rdy[i] != 0) begin
                s.rdy_cnt++;
                if (s.rdy_bs < 0) s.rdy_bs = nbs;
            end
            if (lg_bs[i]) begin
                if (s.gid < 0) s.gid = lg_gid[i];
                s.bs_cnt++;
                s.last_bs = i;
                if (pos >= eb.size() || lg_bit[i] != eb[pos]) s.bit_err++;
                wantv = (!lg_stall[i] && pos % 8 == 7 && pos + 1 < eb.size()) ? (1 << req) : 0;
                if (lg_rdy[i] != wantv) s.rdy_err++;
                if (!lg_stall[i]) pos++;
                nbs++;
            end else if (lg_rdy[i] != 0) begin
                s.rdy_err++;
            end
            s.busy_end = lg_busy[i];
        end
        if (pos != eb.size()) s.bit_err++;
        return s;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = (qd[i].size() > 0) && !drop_valid[i];
            req_data[i*8 +: 8] = (qd[i].size() > 0) ? qd[i][0] : 8'($urandom);
            req_last[i]        = (ql[i].size() > 0) ? ql[i][0] : 1'($urandom);
        end
        if (bs_sending) stuff_stall = planned(bs_seen);
        else            stuff_stall = rand_stall_idle ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic clear_logs();
        lg_bs = {}; lg_bit = {}; lg_stall = {}; lg_eop = {}; lg_busy = {}; lg_und = {};
        lg_rdy = {}; lg_gid = {};
        bs_seen = 0;
    endtask

    task automatic step();
        @(negedge clock);
        lg_bs.push_back(bs_sending);   lg_bit.push_back(out_bit);
        lg_stall.push_back(stuff_stall); lg_eop.push_back(eop);
        lg_busy.push_back(busy);       lg_und.push_back(underrun);
        lg_rdy.push_back(int'(req_ready)); lg_gid.push_back(int'(grant_id));
        if (bs_sending) bs_seen++;
        if (!busy) bs_seen = 0;
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i] && qd[i].size() > 0) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
            end
        end
        @(posedge clock);
        #1;
        drive_inputs();
    endtask

    task automatic run(input int max_cycles, output bit timed_out);
        bit pending;
        clear_logs();
        drive_inputs();
        timed_out = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            step();
            pending = 1'b0;
            for (int i = 0; i < NR; i++) if (qd[i].size() > 0 && !drop_valid[i]) pending = 1'b1;
            if (c > 0 && !pending && !lg_busy[lg_busy.size()-1]) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            qd[i] = {}; ql[i] = {}; drop_valid[i] = 1'b0;
        end
        stall_plan = {};
        rand_stall_idle = 1'b0;
        bs_seen = 0;
        drive_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; req_data = 16'($urandom); req_last = '1; stuff_stall = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({out_bit, bs_sending, eop, busy, underrun, grant_id, req_ready} !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 0",
                     {out_bit, bs_sending, eop, busy, underrun, grant_id, req_ready});
        end
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({bs_sending, busy, req_ready} !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_idle_cycle: got %b want 0", {bs_sending, busy, req_ready});
        end
        @(negedge clock);
        tests_run++;
        if ({bs_sending, busy, out_bit, grant_id} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_first_sync: got %b want 1100", {bs_sending, busy, out_bit, grant_id});
        end
        @(posedge clock); #1;
        do_reset();
    endtask

    // Checks common to all single-packet scenarios are written out per test.
    task automatic test_single_byte();
        logic [7:0] by[$]; bit eb[$]; stats_t s; bit to;
        do_reset();
        qd[0].push_back(8'hC3); ql[0].push_back(1'b1);
        by.push_back(8'hC3);
        run(200, to);
        exp_wire(by, eb);
        s = analyse(eb, 0);
        tests_run++; if (to) begin tests_failed++; $display("FAIL t1_timeout: got 1 want 0"); end
        tests_run++; if (s.bs_cnt != 16) begin tests_failed++; $display("FAIL t1_bs_len: got %0d want 16", s.bs_cnt); end
        tests_run++; if (s.bit_err != 0) begin tests_failed++; $display("FAIL t1_bits: got %0d errors want 0", s.bit_err); end
        tests_run++; if (s.rdy_cnt != 1 || s.rdy_bs != 7) begin tests_failed++; $display("FAIL t1_ready: got cnt %0d at %0d want 1 at 7", s.rdy_cnt, s.rdy_bs); end
        tests_run++; if (s.eop_cnt != 3 || s.first_eop != s.last_bs + 1 || s.last_eop != s.first_eop + 2) begin
            tests_failed++; $display("FAIL t1_eop: got %0d cycles from %0d want 3 from %0d", s.eop_cnt, s.first_eop, s.last_bs + 1); end
        tests_run++; if (s.busy_end !== 1'b0 || s.und_cnt != 0) begin tests_failed++; $display("FAIL t1_end: got busy %0d und %0d want 0 0", s.busy_end, s.und_cnt); end
    endtask

    task automatic test_rr_order();
        int exp_g[$]; int obs_g[$]; int rem[NR]; int ptr; int c; int gap_err; int nbs; bit to;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            for (int p = 0; p < 2; p++) begin qd[i].push_back(8'($urandom)); ql[i].push_back(1'b1); end
            rem[i] = 2;
        end
        ptr = 0;
        while (rem[0] + rem[1] > 0) begin
            for (int k = 0; k < NR; k++) begin
                c = (ptr + k) % NR;
                if (rem[c] > 0) begin exp_g.push_back(c); rem[c]--; ptr = (c + 1) % NR; break; end
            end
        end
        run(400, to);
        gap_err = 0; nbs = 0;
        for (int i = 0; i < lg_bs.size(); i++) begin
            if (lg_bs[i]) nbs++;
            if (lg_bs[i] && (i == 0 || !lg_bs[i-1])) begin
                obs_g.push_back(lg_gid[i]);
                if (i == 0 || lg_busy[i-1]) gap_err++;
            end
        end
        tests_run++; if (to) begin tests_failed++; $display("FAIL t2_timeout: got 1 want 0"); end
        tests_run++; if (obs_g.size() != exp_g.size()) begin tests_failed++; $display("FAIL t2_packets: got %0d want %0d", obs_g.size(), exp_g.size()); end
        for (int k = 0; k < exp_g.size() && k < obs_g.size(); k++) begin
            tests_run++; if (obs_g[k] != exp_g[k]) begin tests_failed++; $display("FAIL t2_grant%0d: got %0d want %0d", k, obs_g[k], exp_g[k]); end
        end
        tests_run++; if (gap_err != 0) begin tests_failed++; $display("FAIL t2_idle_gap: got %0d violations want 0", gap_err); end
        tests_run++; if (nbs != 64) begin tests_failed++; $display("FAIL t2_bs_total: got %0d want 64", nbs); end
    endtask

    task automatic test_stall_mid();
        logic [7:0] by[$]; bit eb[$]; stats_t s; bit to;
        do_reset();
        qd[0].push_back(8'hC3); ql[0].push_back(1'b1);
        by.push_back(8'hC3);
        stall_plan = '{11, 12};
        run(200, to);
        exp_wire(by, eb);
        s = analyse(eb, 0);
        tests_run++; if (to) begin tests_failed++; $display("FAIL t3_timeout: got 1 want 0"); end
        tests_run++; if (s.bs_cnt != 18) begin tests_failed++; $display("FAIL t3_bs_len: got %0d want 18", s.bs_cnt); end
        tests_run++; if (s.bit_err != 0) begin tests_failed++; $display("FAIL t3_bits: got %0d errors want 0", s.bit_err); end
        tests_run++; if (s.rdy_err != 0) begin tests_failed++; $display("FAIL t3_ready: got %0d errors want 0", s.rdy_err); end
    endtask

    task automatic test_stall_sync();
        logic [7:0] by[$]; bit eb[$]; stats_t s; bit to;
        do_reset();
        qd[1].push_back(8'h5E); ql[1].push_back(1'b1);
        by.push_back(8'h5E);
        stall_plan = '{7};
        run(200, to);
        exp_wire(by, eb);
        s = analyse(eb, 1);
        tests_run++; if (to) begin tests_failed++; $display("FAIL t4_timeout: got 1 want 0"); end
        tests_run++; if (s.rdy_cnt != 1 || s.rdy_bs != 8) begin tests_failed++; $display("FAIL t4_ready: got cnt %0d at %0d want 1 at 8", s.rdy_cnt, s.rdy_bs); end
        tests_run++; if (s.bs_cnt != 17 || s.bit_err != 0) begin tests_failed++; $display("FAIL t4_wire: got len %0d err %0d want 17 0", s.bs_cnt, s.bit_err); end
        tests_run++; if (s.gid != 1) begin tests_failed++; $display("FAIL t4_grant: got %0d want 1", s.gid); end
    endtask

    task automatic test_underrun();
        logic [7:0] by[$]; bit eb[$]; stats_t s; bit to;
        do_reset();
        qd[0].push_back(8'h5A); ql[0].push_back(1'b0);
        by.push_back(8'h5A);
        run(200, to);
        exp_wire(by, eb);
        s = analyse(eb, 0);
        tests_run++; if (to) begin tests_failed++; $display("FAIL t5_timeout: got 1 want 0"); end
        tests_run++; if (s.und_cnt != 1 || s.und_idx != s.last_bs) begin tests_failed++; $display("FAIL t5_underrun: got cnt %0d at %0d want 1 at %0d", s.und_cnt, s.und_idx, s.last_bs); end
        tests_run++; if (s.rdy_cnt != 1 || s.rdy_err != 0) begin tests_failed++; $display("FAIL t5_ready: got cnt %0d err %0d want 1 0", s.rdy_cnt, s.rdy_err); end
        tests_run++; if (s.eop_cnt != 3 || s.first_eop != s.last_bs + 1) begin tests_failed++; $display("FAIL t5_eop: got %0d from %0d want 3 from %0d", s.eop_cnt, s.first_eop, s.last_bs + 1); end
        tests_run++; if (s.bs_cnt != 16 || s.busy_end !== 1'b0) begin tests_failed++; $display("FAIL t5_end: got len %0d busy %0d want 16 0", s.bs_cnt, s.busy_end); end
    endtask

    task automatic test_reset_mid();
        bit to; int first_g;
        do_reset();
        for (int k = 0; k < 3; k++) begin qd[0].push_back(8'($urandom)); ql[0].push_back(k == 2); end
        clear_logs();
        drive_inputs();
        repeat (12) step();
        tests_run++; if (lg_bs[lg_bs.size()-1] !== 1'b1) begin tests_failed++; $display("FAIL t6_in_data: got bs %0d want 1", lg_bs[lg_bs.size()-1]); end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({bs_sending, eop, busy, req_ready, underrun} !== 6'd0) begin
            tests_failed++;
            $display("FAIL t6_after_reset: got %b want 0", {bs_sending, eop, busy, req_ready, underrun});
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            qd[i] = {}; ql[i] = {};
            qd[i].push_back(8'($urandom)); ql[i].push_back(1'b1);
        end
        run(300, to);
        first_g = -1;
        foreach (lg_bs[i]) if (lg_bs[i] && first_g < 0) first_g = lg_gid[i];
        tests_run++; if (to) begin tests_failed++; $display("FAIL t6_timeout: got 1 want 0"); end
        tests_run++; if (first_g != 0) begin tests_failed++; $display("FAIL t6_first_grant: got %0d want 0", first_g); end
    endtask

    task automatic test_random();
        logic [7:0] by[$]; bit eb[$]; stats_t s; bit to; int r; int len; int k;
        do_reset();
        for (int it = 0; it < 20; it++) begin
            r = $urandom_range(0, NR - 1);
            len = $urandom_range(1, 4);
            by = {};
            for (int b = 0; b < len; b++) begin
                by.push_back(8'($urandom));
                qd[r].push_back(by[b]); ql[r].push_back(b == len - 1);
            end
            exp_wire(by, eb);
            stall_plan = {};
            for (int j = 0; j < $urandom_range(0, 3); j++) begin
                k = $urandom_range(0, eb.size() - 1);
                if (!planned(k)) stall_plan.push_back(k);
            end
            rand_stall_idle = 1'b1;
            run(300, to);
            s = analyse(eb, r);
            tests_run++; if (to) begin tests_failed++; $display("FAIL rnd%0d_timeout: got 1 want 0", it); end
            tests_run++; if (s.bs_cnt != eb.size() + stall_plan.size()) begin tests_failed++; $display("FAIL rnd%0d_bs_len: got %0d want %0d", it, s.bs_cnt, eb.size() + stall_plan.size()); end
            tests_run++; if (s.bit_err != 0 || s.rdy_err != 0) begin tests_failed++; $display("FAIL rnd%0d_wire: got bit err %0d rdy err %0d want 0 0", it, s.bit_err, s.rdy_err); end
            tests_run++; if (s.eop_cnt != 3 || s.und_cnt != 0 || s.gid != r) begin tests_failed++; $display("FAIL rnd%0d_frame: got eop %0d und %0d gid %0d want 3 0 %0d", it, s.eop_cnt, s.und_cnt, s.gid, r); end
        end
        rand_stall_idle = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_byte();
        test_rr_order();
        test_stall_mid();
        test_stall_sync();
        test_underrun();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
